// File: rtl/mext_pkg.sv
// Shared types and constants for the M-extension multiply/divide sequencer.
// The optional MEXT_EARLY_OUT_EN build lets a zero rs2 skip the iteration phase.
package mext_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } mext_state_e;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   localparam int MEXT_ITERS = 32;

endpackage

// File: rtl/mext_iter_counter.sv
// Down-counter of remaining iterations: clear beats load, load beats decrement.
module mext_iter_counter #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         load,
   input  logic         dec,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] cnt,
   output logic         zero
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec) begin
         cnt <= cnt - W'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/mext_seq_ctrl.sv
// Sequencer for the iterative MUL/DIV datapath: detect, start, ITERS steps, one-cycle valid.
// Define MEXT_EARLY_OUT_EN to let a zero rs2 go straight from START to DONE.
module mext_seq_ctrl
   import mext_pkg::*;
#(
   parameter int ITERS = MEXT_ITERS,
   parameter int CNT_W = $clog2(ITERS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ex_mext_i,
   input  logic [2:0]       ex_funct3_i,
   input  logic [4:0]       ex_waddr_i,
   input  logic             ex_rs2_zero_i,
   input  logic             kill_i,
   output logic             stall_o,
   output logic             mdu_start_o,
   output logic             mdu_step_o,
   output logic             mdu_abort_o,
   output logic [2:0]       mdu_op_o,
   output logic [4:0]       waddr_o,
   output logic             valid_o,
   output logic             busy_o,
   output logic [CNT_W-1:0] iter_cnt_o,
   output logic [1:0]       state_o
);

   // Interface to the datapath: start, step, abort and valid are single-cycle
   // qualifiers with no back-pressure; the datapath acts on every cycle they are
   // high, and valid_o is consumed by the EX/MEM register in that same cycle.

   mext_state_e state_q, state_d;
   logic        early_q, early_d;
   logic        latch;
   logic        stall, start, step, abort, valid;
   logic        cnt_clr, cnt_load, cnt_dec, cnt_zero;
   logic [CNT_W-1:0] cnt;

   mext_iter_counter #(.W(CNT_W)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .clr      (cnt_clr),
      .load     (cnt_load),
      .dec      (cnt_dec),
      .load_val (CNT_W'(ITERS - 1)),
      .cnt      (cnt),
      .zero     (cnt_zero)
   );

`ifdef MEXT_EARLY_OUT_EN
   assign early_d = ex_rs2_zero_i;
`else
   logic unused_rs2_zero;
   assign unused_rs2_zero = ex_rs2_zero_i;
   assign early_d = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         mdu_op_o <= '0;
         waddr_o  <= '0;
         early_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (latch) begin
            mdu_op_o <= ex_funct3_i;
            waddr_o  <= ex_waddr_i;
            early_q  <= early_d;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      latch    = 1'b0;
      stall    = 1'b0;
      start    = 1'b0;
      step     = 1'b0;
      abort    = 1'b0;
      valid    = 1'b0;
      cnt_clr  = 1'b0;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      case (state_q)
         IDLE: begin
            if (ex_mext_i && !kill_i) begin
               stall   = 1'b1;
               latch   = 1'b1;
               state_d = START;
            end
         end
         START: begin
            if (kill_i) begin
               abort   = 1'b1;
               cnt_clr = 1'b1;
               state_d = IDLE;
            end else begin
               start    = 1'b1;
               stall    = 1'b1;
               cnt_load = !early_q;
               state_d  = early_q ? DONE : RUN;
            end
         end
         RUN: begin
            if (kill_i) begin
               abort   = 1'b1;
               cnt_clr = 1'b1;
               state_d = IDLE;
            end else begin
               step  = 1'b1;
               stall = 1'b1;
               // The zero-count cycle is itself a step, giving ITERS steps in total.
               if (cnt_zero) begin
                  state_d = DONE;
               end else begin
                  cnt_dec = 1'b1;
               end
            end
         end
         DONE: begin
            valid   = !kill_i;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Reset forces every combinational output low, so no abort escapes mid-op.
   assign stall_o     = stall & ~rst;
   assign mdu_start_o = start & ~rst;
   assign mdu_step_o  = step  & ~rst;
   assign mdu_abort_o = abort & ~rst;
   assign valid_o     = valid & ~rst;
   assign busy_o      = (state_q != IDLE) & ~rst;
   assign iter_cnt_o  = cnt;
   assign state_o     = rst ? 2'b00 : state_q;

endmodule

// File: tb/tb_mext_seq_ctrl.sv
// Directed bench for mext_seq_ctrl: full ops, back-to-back, kill, mid-op reset, early-out.
module tb_mext_seq_ctrl;
   import mext_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ex_mext_i = 1'b0;
   logic [2:0] ex_funct3_i = '0;
   logic [4:0] ex_waddr_i = '0;
   logic       ex_rs2_zero_i = 1'b0;
   logic       kill_i = 1'b0;
   logic       stall_o, mdu_start_o, mdu_step_o, mdu_abort_o, valid_o, busy_o;
   logic [2:0] mdu_op_o;
   logic [4:0] waddr_o;
   logic [4:0] iter_cnt_o;
   logic [1:0] state_o;

   int n_chk = 0;
   int n_bad = 0;

   mext_seq_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .ex_mext_i     (ex_mext_i),
      .ex_funct3_i   (ex_funct3_i),
      .ex_waddr_i    (ex_waddr_i),
      .ex_rs2_zero_i (ex_rs2_zero_i),
      .kill_i        (kill_i),
      .stall_o       (stall_o),
      .mdu_start_o   (mdu_start_o),
      .mdu_step_o    (mdu_step_o),
      .mdu_abort_o   (mdu_abort_o),
      .mdu_op_o      (mdu_op_o),
      .waddr_o       (waddr_o),
      .valid_o       (valid_o),
      .busy_o        (busy_o),
      .iter_cnt_o    (iter_cnt_o),
      .state_o       (state_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      ex_mext_i     = 1'b0;
      kill_i        = 1'b0;
      ex_rs2_zero_i = 1'b0;
      #1;
   endtask

   // Drives one op from its detect cycle (cycle 1). kill_at > 0 raises kill_i
   // on cycle kill_at. Returns in the last sampled cycle without touching inputs.
   task automatic run_op(input logic [2:0] f3, input logic [4:0] wa, input logic rs2z,
                         input int kill_at,
                         output int n_stall, output int n_step, output int n_start,
                         output int n_abort, output int valid_cyc, output int cnt_run1,
                         output int stall_c1, output int stall_at_valid, output int done);
      n_stall = 0; n_step = 0; n_start = 0; n_abort = 0;
      valid_cyc = 0; cnt_run1 = -1; stall_c1 = 0; stall_at_valid = -1; done = 0;
      for (int cyc = 1; cyc <= 100; cyc++) begin
         @(negedge clk);
         ex_mext_i     = 1'b1;
         ex_funct3_i   = f3;
         ex_waddr_i    = wa;
         ex_rs2_zero_i = rs2z;
         kill_i        = (kill_at > 0) && (cyc == kill_at);
         #1;
         if (stall_o) n_stall++;
         if (mdu_step_o) n_step++;
         if (mdu_start_o) n_start++;
         if (mdu_abort_o) n_abort++;
         if (cyc == 1) stall_c1 = int'(stall_o);
         if (cyc == 3) cnt_run1 = int'(iter_cnt_o);
         if (valid_o && valid_cyc == 0) begin
            valid_cyc = cyc;
            stall_at_valid = int'(stall_o);
         end
         if (valid_o || mdu_abort_o || kill_i) begin
            done = 1;
            break;
         end
      end
   endtask

   int ns, nst, nsa, nab, vc, c1, sc1, sav, dn;
   int e_stall, e_step, e_valid;

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_stall", int'(stall_o), 0);
      chk("rst_busy", int'(busy_o), 0);
      chk("rst_valid", int'(valid_o), 0);
      chk("rst_cnt", int'(iter_cnt_o), 0);
      chk("rst_op", int'(mdu_op_o), 0);
      chk("rst_waddr", int'(waddr_o), 0);
      chk("rst_state", int'(state_o), 0);

      // Full MUL
      run_op(F3_MUL, 5'd5, 1'b0, 0, ns, nst, nsa, nab, vc, c1, sc1, sav, dn);
      chk("mul_done", dn, 1);
      chk("mul_stall", ns, 34);
      chk("mul_steps", nst, 32);
      chk("mul_start", nsa, 1);
      chk("mul_abort", nab, 0);
      chk("mul_valid_cyc", vc, 35);
      chk("mul_cnt_run1", c1, 31);
      chk("mul_waddr", int'(waddr_o), 5);
      chk("mul_op", int'(mdu_op_o), 0);
      idle_cycle();
      chk("mul_after_busy", int'(busy_o), 0);
      chk("mul_after_valid", int'(valid_o), 0);
      chk("mul_hold_waddr", int'(waddr_o), 5);

      // DIVU immediately followed by REM
      run_op(F3_DIVU, 5'd7, 1'b0, 0, ns, nst, nsa, nab, vc, c1, sc1, sav, dn);
      chk("divu_valid_cyc", vc, 35);
      chk("divu_stall_done", sav, 0);
      chk("divu_op", int'(mdu_op_o), 5);
      chk("divu_waddr", int'(waddr_o), 7);
      run_op(F3_REM, 5'd9, 1'b0, 0, ns, nst, nsa, nab, vc, c1, sc1, sav, dn);
      chk("rem_stall_c1", sc1, 1);
      chk("rem_stall", ns, 34);
      chk("rem_steps", nst, 32);
      chk("rem_valid_cyc", vc, 35);
      chk("rem_op", int'(mdu_op_o), 6);
      chk("rem_waddr", int'(waddr_o), 9);
      idle_cycle();

      // Kill on the 10th RUN cycle (cycle 12)
      run_op(F3_MULHU, 5'd3, 1'b0, 12, ns, nst, nsa, nab, vc, c1, sc1, sav, dn);
      chk("kill_abort", nab, 1);
      chk("kill_steps", nst, 9);
      chk("kill_valid", vc, 0);
      chk("kill_stall", ns, 11);
      idle_cycle();
      chk("kill_after_busy", int'(busy_o), 0);
      chk("kill_after_abort", int'(mdu_abort_o), 0);
      chk("kill_after_step", int'(mdu_step_o), 0);
      chk("kill_after_valid", int'(valid_o), 0);
      chk("kill_after_cnt", int'(iter_cnt_o), 0);

      // Kill in DONE (cycle 35): valid suppressed, back to IDLE
      run_op(F3_MULH, 5'd4, 1'b0, 35, ns, nst, nsa, nab, vc, c1, sc1, sav, dn);
      chk("kdone_steps", nst, 32);
      chk("kdone_valid", vc, 0);
      chk("kdone_abort", nab, 0);
      idle_cycle();
      chk("kdone_busy", int'(busy_o), 0);

      // Reset in the middle of RUN
      @(negedge clk);
      ex_mext_i = 1'b1; ex_funct3_i = F3_MUL; ex_waddr_i = 5'd12;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      ex_mext_i = 1'b0;
      #1;
      chk("rstmid_abort", int'(mdu_abort_o), 0);
      chk("rstmid_stall", int'(stall_o), 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rstmid_busy", int'(busy_o), 0);
      chk("rstmid_step", int'(mdu_step_o), 0);
      chk("rstmid_cnt", int'(iter_cnt_o), 0);
      chk("rstmid_op", int'(mdu_op_o), 0);
      chk("rstmid_waddr", int'(waddr_o), 0);
      chk("rstmid_abort2", int'(mdu_abort_o), 0);
      run_op(F3_MUL, 5'd1, 1'b0, 0, ns, nst, nsa, nab, vc, c1, sc1, sav, dn);
      chk("post_rst_valid_cyc", vc, 35);
      chk("post_rst_steps", nst, 32);
      chk("post_rst_stall", ns, 34);
      chk("post_rst_waddr", int'(waddr_o), 1);
      idle_cycle();

      // Detect together with kill in IDLE
      @(negedge clk);
      ex_mext_i = 1'b1; kill_i = 1'b1; ex_funct3_i = F3_DIV;
      #1;
      chk("ik_stall", int'(stall_o), 0);
      idle_cycle();
      chk("ik_busy", int'(busy_o), 0);
      chk("ik_start", int'(mdu_start_o), 0);

      // DIV with rs2 == 0
`ifdef MEXT_EARLY_OUT_EN
      e_stall = 2;  e_step = 0;  e_valid = 3;
`else
      e_stall = 34; e_step = 32; e_valid = 35;
`endif
      run_op(F3_DIV, 5'd2, 1'b1, 0, ns, nst, nsa, nab, vc, c1, sc1, sav, dn);
      chk("z_stall", ns, e_stall);
      chk("z_steps", nst, e_step);
      chk("z_valid_cyc", vc, e_valid);
      chk("z_start", nsa, 1);
      chk("z_op", int'(mdu_op_o), 4);
      idle_cycle();
      chk("z_after_busy", int'(busy_o), 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
